// File: rtl/sobel_window_gen_if.sv
// Pixel-stream in / 3x3 window out bundle between a raster source, the window generator and the Sobel core.
interface sobel_window_gen_if #(
    parameter int unsigned DW = 8
) ();
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic [DW-1:0] p0;
    logic [DW-1:0] p1;
    logic [DW-1:0] p2;
    logic [DW-1:0] p3;
    logic [DW-1:0] p5;
    logic [DW-1:0] p6;
    logic [DW-1:0] p7;
    logic [DW-1:0] p8;
    logic          out_valid;
    logic          border;
    logic          frame_done;

    // Pixel source / window consumer side
    modport master (
        output in_data, in_valid, in_sof,
        input  in_ready,
        input  p0, p1, p2, p3, p5, p6, p7, p8, out_valid, border, frame_done
    );

    // Window generator side
    modport slave (
        input  in_data, in_valid, in_sof,
        output in_ready,
        output p0, p1, p2, p3, p5, p6, p7, p8, out_valid, border, frame_done
    );
endinterface

// File: rtl/sobel_window_gen.sv
// Raster pixel stream -> 3x3 neighbourhood per centre pixel, border windows zeroed and flagged,
// trailing WIDTH+1 windows flushed after the last pixel of a frame.
module sobel_window_gen #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned DW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    sobel_window_gen_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned RW = $clog2(HEIGHT);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_in_ready;

    // input (pixel k) and output (centre) position counters
    logic [CW-1:0] r_icol;
    logic [RW-1:0] r_irow;
    logic [CW-1:0] r_ocol;
    logic [RW-1:0] r_orow;

    // line buffers: lb0 holds the previous line, lb1 the one before; r_rd* are prefetched reads
    logic [DW-1:0] r_lb0 [WIDTH];
    logic [DW-1:0] r_lb1 [WIDTH];
    logic [DW-1:0] r_rd0;
    logic [DW-1:0] r_rd1;

    // two older window columns (top/mid/bot); the newest column comes straight from rd1/rd0/in_data
    logic [DW-1:0] r_c0_top, r_c0_mid, r_c0_bot;
    logic [DW-1:0] r_c1_top, r_c1_mid, r_c1_bot;

    // registered outputs; index order p0,p1,p2,p3,p5,p6,p7,p8
    logic [DW-1:0] r_win [8];
    logic          r_out_valid;
    logic          r_border;
    logic          r_frame_done;

    logic [DW-1:0] w_win [8];
    logic          w_emit;
    logic          w_border;
    logic          w_frame_done;

    logic          w_accept;
    logic          w_start;
    logic          w_take;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;
    logic          w_in_last;
    logic          w_in_fill_end;
    logic          w_out_last;
    logic          w_out_border;

    // handshake decode and position of the pixel being accepted (sof restarts at k=0)
    assign w_accept      = bus.in_valid & r_in_ready;
    assign w_start       = w_accept & bus.in_sof;
    assign w_take        = w_accept & ((r_state != S_IDLE) | bus.in_sof);
    assign w_col         = w_start ? '0 : r_icol;
    assign w_row         = w_start ? '0 : r_irow;
    assign w_col_nxt     = (w_col == CW'(WIDTH - 1)) ? '0 : CW'(w_col + 1'b1);
    assign w_row_nxt     = (w_col != CW'(WIDTH - 1)) ? w_row :
                           (w_row == RW'(HEIGHT - 1)) ? '0 : RW'(w_row + 1'b1);
    assign w_in_last     = (w_row == RW'(HEIGHT - 1)) && (w_col == CW'(WIDTH - 1));
    assign w_in_fill_end = (w_row == RW'(1)) && (w_col == '0);
    assign w_out_last    = (r_orow == RW'(HEIGHT - 1)) && (r_ocol == CW'(WIDTH - 1));
    assign w_out_border  = (r_orow == '0) || (r_orow == RW'(HEIGHT - 1)) ||
                           (r_ocol == '0) || (r_ocol == CW'(WIDTH - 1));

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_FILL;
            S_FILL:  if (w_start)                        w_state_nxt = S_FILL;
                     else if (w_accept && w_in_fill_end) w_state_nxt = S_RUN;
            S_RUN:   if (w_start)                        w_state_nxt = S_FILL;
                     else if (w_accept && w_in_last)     w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_out_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // window output decode: RUN emits on each non-sof accept, FLUSH emits border windows every cycle
    always_comb begin
        w_emit       = 1'b0;
        w_border     = 1'b0;
        w_frame_done = 1'b0;
        for (int i = 0; i < 8; i++) w_win[i] = '0;
        unique case (r_state)
            S_RUN: begin
                if (w_accept && !bus.in_sof) begin
                    w_emit   = 1'b1;
                    w_border = w_out_border;
                    if (!w_out_border) begin
                        w_win[0] = r_c0_top;
                        w_win[1] = r_c1_top;
                        w_win[2] = r_rd1;
                        w_win[3] = r_c0_mid;
                        w_win[4] = r_rd0;
                        w_win[5] = r_c0_bot;
                        w_win[6] = r_c1_bot;
                        w_win[7] = bus.in_data;
                    end
                end
            end
            S_FLUSH: begin
                w_emit       = 1'b1;
                w_border     = 1'b1;
                w_frame_done = w_out_last;
            end
            default: ;
        endcase
    end

    // in_ready is low only while flushing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_in_ready <= 1'b0;
        else     r_in_ready <= (w_state_nxt != S_FLUSH);
    end

    // input and centre counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_icol <= '0;
            r_irow <= '0;
            r_ocol <= '0;
            r_orow <= '0;
        end else begin
            if (w_take) begin
                r_icol <= w_col_nxt;
                r_irow <= w_row_nxt;
            end
            if (w_start) begin
                r_ocol <= '0;
                r_orow <= '0;
            end else if (w_emit) begin
                r_ocol <= (r_ocol == CW'(WIDTH - 1)) ? '0 : CW'(r_ocol + 1'b1);
                if (r_ocol == CW'(WIDTH - 1))
                    r_orow <= (r_orow == RW'(HEIGHT - 1)) ? '0 : RW'(r_orow + 1'b1);
            end
        end
    end

    // line buffers: write at the current column, prefetch the next column so reads are registered
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_lb0[w_col] <= bus.in_data;
            r_lb1[w_col] <= r_rd0;
            r_rd0        <= r_lb0[w_col_nxt];
            r_rd1        <= r_lb1[w_col_nxt];
        end
    end

    // shift window columns on every stored pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c0_top <= '0; r_c0_mid <= '0; r_c0_bot <= '0;
            r_c1_top <= '0; r_c1_mid <= '0; r_c1_bot <= '0;
        end else if (w_take) begin
            r_c0_top <= r_c1_top; r_c0_mid <= r_c1_mid; r_c0_bot <= r_c1_bot;
            r_c1_top <= r_rd1;    r_c1_mid <= r_rd0;    r_c1_bot <= bus.in_data;
        end
    end

    // output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_win[i] <= '0;
            r_out_valid  <= 1'b0;
            r_border     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) r_win[i] <= w_win[i];
            r_out_valid  <= w_emit;
            r_border     <= w_border;
            r_frame_done <= w_frame_done;
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.p0         = r_win[0];
    assign bus.p1         = r_win[1];
    assign bus.p2         = r_win[2];
    assign bus.p3         = r_win[3];
    assign bus.p5         = r_win[4];
    assign bus.p6         = r_win[5];
    assign bus.p7         = r_win[6];
    assign bus.p8         = r_win[7];
    assign bus.out_valid  = r_out_valid;
    assign bus.border     = r_border;
    assign bus.frame_done = r_frame_done;

endmodule
